// File: rtl/rvga_types.sv
// Shared types for the rvga memory subsystem.
//   rvga_word         32-bit address/data word
//   rvga_cacheline    256-bit cache line
//   rvga_arb_state_e  DDR arbiter FSM states
//   rvga_arb_client_e DDR arbiter clients, used for round-robin history
package rvga_types;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 256;

    typedef logic [WORD_W-1:0] rvga_word;
    typedef logic [LINE_W-1:0] rvga_cacheline;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ICACHE_BUSY = 2'd1,
        DCACHE_BUSY = 2'd2
    } rvga_arb_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } rvga_arb_client_e;

endpackage

// File: rtl/rvga_ddr_arbiter.sv
// Merges the icache and dcache DDR miss/writeback ports onto one memory port.
// Whole-line transactions are granted one at a time with round-robin fairness;
// the memory request is registered and the response is routed only to the
// granted cache.
//   clk, rst                 clock, synchronous active-high reset
//   icache_ddr_*             icache fill request in, fill data/resp out
//   dcache_ddr_*             dcache fill/writeback request in, fill data/resp out
//   arb_mem_*                registered request toward memory
//   mem_arb_rdata/resp       memory completion
//   arb_timeout              sticky: a granted transaction waited too long
module rvga_ddr_arbiter
    import rvga_types::*;
#(
    parameter int unsigned timeout_cycles_p = 1023,
    parameter int unsigned cnt_width_p      = 10
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [WORD_W-1:0] icache_ddr_addr,
    input  logic              icache_ddr_read,
    output logic [LINE_W-1:0] ddr_icache_rdata,
    output logic              ddr_icache_resp,

    input  logic [WORD_W-1:0] dcache_ddr_addr,
    input  logic              dcache_ddr_read,
    input  logic              dcache_ddr_write,
    input  logic [LINE_W-1:0] dcache_ddr_wdata,
    output logic [LINE_W-1:0] ddr_dcache_rdata,
    output logic              ddr_dcache_resp,

    output logic [WORD_W-1:0] arb_mem_addr,
    output logic              arb_mem_read,
    output logic              arb_mem_write,
    output logic [LINE_W-1:0] arb_mem_wdata,
    input  logic [LINE_W-1:0] mem_arb_rdata,
    input  logic              mem_arb_resp,

    output logic              arb_timeout
);

    localparam logic [cnt_width_p-1:0] CNT_MAX   = '1;
    localparam logic [cnt_width_p-1:0] CNT_LIMIT = cnt_width_p'(timeout_cycles_p);

    rvga_arb_state_e        state_q,      state_d;
    rvga_arb_client_e       last_grant_q, last_grant_d;
    logic [cnt_width_p-1:0] cnt_q,        cnt_d;
    logic                   timeout_q,    timeout_d;
    rvga_word               addr_q,       addr_d;
    logic                   read_q,       read_d;
    logic                   write_q,      write_d;
    rvga_cacheline          wdata_q,      wdata_d;

    logic icache_req;
    logic dcache_req;

    assign icache_req = icache_ddr_read;
    assign dcache_req = dcache_ddr_read | dcache_ddr_write;

    // State and request register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= DCACHE;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            addr_q       <= addr_d;
            read_q       <= read_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state: grant arbitration, request capture, wait counter
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        addr_d       = addr_q;
        read_d       = read_q;
        write_d      = write_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                // icache wins unless dcache also wants it and icache went last
                if (icache_req && (!dcache_req || last_grant_q == DCACHE)) begin
                    state_d      = ICACHE_BUSY;
                    last_grant_d = ICACHE;
                    cnt_d        = '0;
                    addr_d       = icache_ddr_addr;
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    wdata_d      = '0;
                end else if (dcache_req) begin
                    state_d      = DCACHE_BUSY;
                    last_grant_d = DCACHE;
                    cnt_d        = '0;
                    addr_d       = dcache_ddr_addr;
                    // read+write together is illegal; treat it as a writeback
                    read_d       = dcache_ddr_read & ~dcache_ddr_write;
                    write_d      = dcache_ddr_write;
                    wdata_d      = dcache_ddr_wdata;
                end
            end
            ICACHE_BUSY, DCACHE_BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + cnt_width_p'(1);
                end
                if (cnt_d == CNT_LIMIT) begin
                    timeout_d = 1'b1;
                end
                if (mem_arb_resp) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // Outputs: registered request, combinational response demux
    always_comb begin
        arb_mem_addr     = addr_q;
        arb_mem_read     = read_q;
        arb_mem_write    = write_q;
        arb_mem_wdata    = wdata_q;
        arb_timeout      = timeout_q;
        ddr_icache_resp  = 1'b0;
        ddr_dcache_resp  = 1'b0;
        ddr_icache_rdata = '0;
        ddr_dcache_rdata = '0;

        // A response seen while IDLE is stray and reaches nobody
        if (!rst && mem_arb_resp) begin
            if (state_q == ICACHE_BUSY) begin
                ddr_icache_resp  = 1'b1;
                ddr_icache_rdata = mem_arb_rdata;
            end else if (state_q == DCACHE_BUSY) begin
                ddr_dcache_resp  = 1'b1;
                ddr_dcache_rdata = mem_arb_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rvga_ddr_arbiter.sv
// Directed bench for rvga_ddr_arbiter: grant order, request capture,
// response routing, stray responses, mid-transaction reset and timeout.
module tb_rvga_ddr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icache_ddr_addr;
    logic         icache_ddr_read;
    logic [255:0] ddr_icache_rdata;
    logic         ddr_icache_resp;
    logic [31:0]  dcache_ddr_addr;
    logic         dcache_ddr_read;
    logic         dcache_ddr_write;
    logic [255:0] dcache_ddr_wdata;
    logic [255:0] ddr_dcache_rdata;
    logic         ddr_dcache_resp;
    logic [31:0]  arb_mem_addr;
    logic         arb_mem_read;
    logic         arb_mem_write;
    logic [255:0] arb_mem_wdata;
    logic [255:0] mem_arb_rdata;
    logic         mem_arb_resp;
    logic         arb_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    rvga_ddr_arbiter #(
        .timeout_cycles_p(1023),
        .cnt_width_p     (10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .icache_ddr_addr  (icache_ddr_addr),
        .icache_ddr_read  (icache_ddr_read),
        .ddr_icache_rdata (ddr_icache_rdata),
        .ddr_icache_resp  (ddr_icache_resp),
        .dcache_ddr_addr  (dcache_ddr_addr),
        .dcache_ddr_read  (dcache_ddr_read),
        .dcache_ddr_write (dcache_ddr_write),
        .dcache_ddr_wdata (dcache_ddr_wdata),
        .ddr_dcache_rdata (ddr_dcache_rdata),
        .ddr_dcache_resp  (ddr_dcache_resp),
        .arb_mem_addr     (arb_mem_addr),
        .arb_mem_read     (arb_mem_read),
        .arb_mem_write    (arb_mem_write),
        .arb_mem_wdata    (arb_mem_wdata),
        .mem_arb_rdata    (mem_arb_rdata),
        .mem_arb_resp     (mem_arb_resp),
        .arb_timeout      (arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; registered outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [255:0] d_i;
    logic [255:0] d_d;
    logic [255:0] a5;

    initial begin
        d_i = {8{32'hDEADBEEF}};
        d_d = {8{32'h12345678}};
        a5  = {32{8'hA5}};

        rst = 1'b1;
        icache_ddr_addr = '0; icache_ddr_read = 1'b0;
        dcache_ddr_addr = '0; dcache_ddr_read = 1'b0; dcache_ddr_write = 1'b0;
        dcache_ddr_wdata = '0; mem_arb_rdata = '0; mem_arb_resp = 1'b0;
        ticks(2);
        chk("rst_read",    256'(arb_mem_read), 256'(0));
        chk("rst_write",   256'(arb_mem_write), 256'(0));
        chk("rst_addr",    256'(arb_mem_addr), 256'(0));
        chk("rst_timeout", 256'(arb_timeout), 256'(0));
        rst = 1'b0;
        tick();

        // icache read alone, response 5 cycles after strobe
        icache_ddr_addr = 32'h100; icache_ddr_read = 1'b1;
        tick();
        chk("i_addr",  256'(arb_mem_addr), 256'(32'h100));
        chk("i_read",  256'(arb_mem_read), 256'(1));
        chk("i_write", 256'(arb_mem_write), 256'(0));
        ticks(4);
        chk("i_noresp_early", 256'(ddr_icache_resp), 256'(0));
        mem_arb_resp = 1'b1; mem_arb_rdata = d_i;
        #1;
        chk("i_resp",        256'(ddr_icache_resp), 256'(1));
        chk("i_rdata",       ddr_icache_rdata, d_i);
        chk("i_other_resp",  256'(ddr_dcache_resp), 256'(0));
        chk("i_other_rdata", ddr_dcache_rdata, 256'(0));
        tick();
        mem_arb_resp = 1'b0; icache_ddr_read = 1'b0;
        #1;
        chk("i_read_clr", 256'(arb_mem_read), 256'(0));
        chk("i_resp_clr", 256'(ddr_icache_resp), 256'(0));
        tick();
        chk("i_no_regrant", 256'(arb_mem_read), 256'(0));

        // Both request together after reset: icache first, then alternate
        rst = 1'b1; tick(); rst = 1'b0; tick();
        icache_ddr_addr = 32'h300; icache_ddr_read = 1'b1;
        dcache_ddr_addr = 32'h400; dcache_ddr_read = 1'b1;
        tick();
        chk("rr1_addr", 256'(arb_mem_addr), 256'(32'h300));
        tick();
        mem_arb_resp = 1'b1; mem_arb_rdata = d_i;
        #1;
        chk("rr1_iresp", 256'(ddr_icache_resp), 256'(1));
        chk("rr1_dresp", 256'(ddr_dcache_resp), 256'(0));
        tick();
        mem_arb_resp = 1'b0; icache_ddr_read = 1'b0;
        #1;
        chk("rr1_idle", 256'(arb_mem_read), 256'(0));
        tick();
        chk("rr2_addr", 256'(arb_mem_addr), 256'(32'h400));
        chk("rr2_read", 256'(arb_mem_read), 256'(1));
        icache_ddr_read = 1'b1;
        tick();
        mem_arb_resp = 1'b1; mem_arb_rdata = d_d;
        #1;
        chk("rr2_dresp",  256'(ddr_dcache_resp), 256'(1));
        chk("rr2_drdata", ddr_dcache_rdata, d_d);
        chk("rr2_iresp",  256'(ddr_icache_resp), 256'(0));
        chk("rr2_irdata", ddr_icache_rdata, 256'(0));
        tick();
        mem_arb_resp = 1'b0; dcache_ddr_read = 1'b0;
        tick();
        chk("rr3_addr", 256'(arb_mem_addr), 256'(32'h300));
        chk("rr3_read", 256'(arb_mem_read), 256'(1));
        mem_arb_resp = 1'b1;
        #1;
        chk("rr3_iresp", 256'(ddr_icache_resp), 256'(1));
        tick();
        mem_arb_resp = 1'b0; icache_ddr_read = 1'b0;
        tick();

        // dcache writeback; inputs changed mid-transaction must not leak through
        dcache_ddr_addr = 32'h2000; dcache_ddr_write = 1'b1; dcache_ddr_wdata = a5;
        tick();
        chk("w_write", 256'(arb_mem_write), 256'(1));
        chk("w_read",  256'(arb_mem_read), 256'(0));
        chk("w_wdata", arb_mem_wdata, a5);
        dcache_ddr_addr = 32'h3000; dcache_ddr_wdata = '0;
        ticks(2);
        chk("w_hold_addr",  256'(arb_mem_addr), 256'(32'h2000));
        chk("w_hold_wdata", arb_mem_wdata, a5);
        mem_arb_resp = 1'b1;
        #1;
        chk("w_dresp", 256'(ddr_dcache_resp), 256'(1));
        tick();
        mem_arb_resp = 1'b0; dcache_ddr_write = 1'b0;
        #1;
        chk("w_write_clr", 256'(arb_mem_write), 256'(0));
        tick();

        // Illegal read+write from dcache: write wins
        dcache_ddr_addr = 32'h2040; dcache_ddr_read = 1'b1; dcache_ddr_write = 1'b1;
        tick();
        chk("rw_write", 256'(arb_mem_write), 256'(1));
        chk("rw_read",  256'(arb_mem_read), 256'(0));
        mem_arb_resp = 1'b1;
        tick();
        mem_arb_resp = 1'b0; dcache_ddr_read = 1'b0; dcache_ddr_write = 1'b0;
        tick();

        // Stray response while IDLE
        mem_arb_resp = 1'b1; mem_arb_rdata = d_i;
        #1;
        chk("stray_iresp", 256'(ddr_icache_resp), 256'(0));
        chk("stray_dresp", 256'(ddr_dcache_resp), 256'(0));
        tick();
        mem_arb_resp = 1'b0;
        chk("stray_read", 256'(arb_mem_read), 256'(0));

        // Reset during DCACHE_BUSY, then a late response
        dcache_ddr_addr = 32'h5000; dcache_ddr_read = 1'b1;
        tick();
        chk("rb_read", 256'(arb_mem_read), 256'(1));
        tick();
        rst = 1'b1;
        tick();
        chk("rb_read_drop", 256'(arb_mem_read), 256'(0));
        chk("rb_addr_drop", 256'(arb_mem_addr), 256'(0));
        dcache_ddr_read = 1'b0; rst = 1'b0;
        tick();
        mem_arb_resp = 1'b1;
        #1;
        chk("rb_late_dresp", 256'(ddr_dcache_resp), 256'(0));
        tick();
        mem_arb_resp = 1'b0;
        chk("rb_late_read", 256'(arb_mem_read), 256'(0));

        // Timeout: sets exactly at 1023 cycles after the strobe, stays set
        icache_ddr_addr = 32'h600; icache_ddr_read = 1'b1;
        tick();
        chk("to_start", 256'(arb_timeout), 256'(0));
        ticks(1022);
        chk("to_before", 256'(arb_timeout), 256'(0));
        tick();
        chk("to_at", 256'(arb_timeout), 256'(1));
        chk("to_still_read", 256'(arb_mem_read), 256'(1));
        mem_arb_resp = 1'b1; mem_arb_rdata = d_i;
        #1;
        chk("to_iresp", 256'(ddr_icache_resp), 256'(1));
        tick();
        mem_arb_resp = 1'b0; icache_ddr_read = 1'b0;
        ticks(3);
        chk("to_sticky", 256'(arb_timeout), 256'(1));
        rst = 1'b1;
        tick();
        chk("to_rst_clr", 256'(arb_timeout), 256'(0));
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
